// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard/pipeline-control unit.
// Optional feature macro used by hazard_ctrl_mc: HAZARD_PERF_EN.
package hazard_pkg;

  // Default number of producer stages after E (0 = M, 1 = W).
  localparam int FWD_STAGES_DEF = 2;
  // Forward-select width for the default stage count.
  localparam int SEL_W = $clog2(FWD_STAGES_DEF + 1);

  // Default redirect targets.
  localparam logic [31:0] EXC_VEC_DEF   = 32'hbfc0_0380;
  localparam logic [31:0] ERET_CODE_DEF = 32'h0000_000e;

  // excepttype codes as reported by the M stage.
  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Exception-redirect FSM states.
  typedef enum logic [0:0] {
    EXC_IDLE = 1'b0,
    EXC_HOLD = 1'b1
  } exc_state_e;

  // Saturating 32-bit increment used by the optional event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    logic [31:0] res;
    res = val;
    if (en && (val != 32'hffff_ffff)) begin
      res = val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: priority encoder matching one source register against the
// destinations of the producer stages after E. The youngest (lowest index)
// writing stage wins; register 0 never matches.
module hazard_fwd_sel #(
  parameter int STAGES = 2,
  parameter int SW     = $clog2(STAGES + 1)
) (
  input  logic [4:0]          src_i,
  input  logic                en_i,
  input  logic [5*STAGES-1:0] wreg_s_i,
  input  logic [STAGES-1:0]   regwrite_s_i,
  output logic [SW-1:0]       sel_o
);

  // Scan oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    sel_o = {SW{1'b0}};
    for (int k = STAGES - 1; k >= 0; k--) begin
      sel_o = (en_i && (src_i != 5'd0) && regwrite_s_i[k] &&
               (wreg_s_i[5*k +: 5] == src_i)) ? SW'(k + 1) : sel_o;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: hazard and pipeline-control unit for the 5-stage MIPS core.
// Drives stall/flush/forward selects, owns the multi-cycle MDU occupancy
// counter and an exception-redirect FSM that defers a flush raised during a
// memory stall. Optional event counters are enabled by HAZARD_PERF_EN.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int          FWD_STAGES = FWD_STAGES_DEF,
  parameter int          MDU_LAT    = 8,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
  localparam int         FSEL_W     = $clog2(FWD_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [4:0]              rs_d_i,
  input  logic [4:0]              rt_d_i,
  input  logic                    use_rs_d_i,
  input  logic                    use_rt_d_i,
  input  logic                    early_d_i,
  input  logic [4:0]              rs_e_i,
  input  logic [4:0]              rt_e_i,
  input  logic [4:0]              wreg_e_i,
  input  logic                    regwrite_e_i,
  input  logic                    memtoreg_e_i,
  input  logic [5*FWD_STAGES-1:0] wreg_s_i,
  input  logic [FWD_STAGES-1:0]   regwrite_s_i,
  input  logic [FWD_STAGES-1:0]   ready_s_i,
  input  logic                    mdu_start_e_i,
  input  logic                    inst_stall_i,
  input  logic                    data_stall_i,
  input  logic [31:0]             exc_type_m_i,
  input  logic [31:0]             epc_m_i,
  output logic [FSEL_W-1:0]       fwd_a_d_o,
  output logic [FSEL_W-1:0]       fwd_b_d_o,
  output logic [FSEL_W-1:0]       fwd_a_e_o,
  output logic [FSEL_W-1:0]       fwd_b_e_o,
  output logic                    stall_f_o,
  output logic                    stall_d_o,
  output logic                    stall_e_o,
  output logic                    stall_m_o,
  output logic                    flush_f_o,
  output logic                    flush_d_o,
  output logic                    flush_e_o,
  output logic                    flush_m_o,
  output logic                    flush_w_o,
  output logic [31:0]             new_pc_o,
`ifdef HAZARD_PERF_EN
  output logic [31:0]             perf_hz_cyc_o,
  output logic [31:0]             perf_mem_cyc_o,
  output logic [31:0]             perf_mdu_cyc_o,
`endif
  output logic                    mdu_done_o
);

  // Counter only needs to hold MDU_LAT-1.
  localparam int   MDU_W    = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic MDU_MULT = (MDU_LAT > 1) ? 1'b1 : 1'b0;

  logic [MDU_W-1:0] mdu_cnt_q, mdu_cnt_d;
  exc_state_e       exc_state_q, exc_state_d;
  logic [31:0]      exc_type_q, exc_type_d;
  logic [31:0]      epc_q, epc_d;

  logic        mem_stall;
  logic        live_exc;
  logic        redirect;
  logic [31:0] sel_type;
  logic [31:0] sel_epc;
  logic        mdu_idle;
  logic        mdu_stall;
  logic        hz;
  logic        used_rs, used_rt;
  logic        rdy_a_d, rdy_b_d;

  // ---------------- forward selects ----------------
  hazard_fwd_sel #(.STAGES(FWD_STAGES), .SW(FSEL_W)) u_fwd_a_d (
    .src_i(rs_d_i), .en_i(early_d_i), .wreg_s_i(wreg_s_i),
    .regwrite_s_i(regwrite_s_i), .sel_o(fwd_a_d_o)
  );
  hazard_fwd_sel #(.STAGES(FWD_STAGES), .SW(FSEL_W)) u_fwd_b_d (
    .src_i(rt_d_i), .en_i(early_d_i), .wreg_s_i(wreg_s_i),
    .regwrite_s_i(regwrite_s_i), .sel_o(fwd_b_d_o)
  );
  hazard_fwd_sel #(.STAGES(FWD_STAGES), .SW(FSEL_W)) u_fwd_a_e (
    .src_i(rs_e_i), .en_i(1'b1), .wreg_s_i(wreg_s_i),
    .regwrite_s_i(regwrite_s_i), .sel_o(fwd_a_e_o)
  );
  hazard_fwd_sel #(.STAGES(FWD_STAGES), .SW(FSEL_W)) u_fwd_b_e (
    .src_i(rt_e_i), .en_i(1'b1), .wreg_s_i(wreg_s_i),
    .regwrite_s_i(regwrite_s_i), .sel_o(fwd_b_e_o)
  );

  // Readiness of the stage each D operand is forwarded from (1 when none).
  always_comb begin
    rdy_a_d = 1'b1;
    rdy_b_d = 1'b1;
    for (int k = 0; k < FWD_STAGES; k++) begin
      rdy_a_d = (fwd_a_d_o == FSEL_W'(k + 1)) ? ready_s_i[k] : rdy_a_d;
      rdy_b_d = (fwd_b_d_o == FSEL_W'(k + 1)) ? ready_s_i[k] : rdy_b_d;
    end
  end

  // Data hazard detection: load-use, early operand from E, early operand not ready.
  always_comb begin
    used_rs = use_rs_d_i && (rs_d_i != 5'd0) && (wreg_e_i == rs_d_i);
    used_rt = use_rt_d_i && (rt_d_i != 5'd0) && (wreg_e_i == rt_d_i);
    hz = (memtoreg_e_i && (used_rs || used_rt)) ||
         (early_d_i && regwrite_e_i && (used_rs || used_rt)) ||
         (use_rs_d_i && (fwd_a_d_o != {FSEL_W{1'b0}}) && !rdy_a_d) ||
         (use_rt_d_i && (fwd_b_d_o != {FSEL_W{1'b0}}) && !rdy_b_d);
  end

  // ---------------- exception FSM ----------------
  // Redirect decision, deferral during memory stalls and latch of type/EPC.
  always_comb begin
    mem_stall   = inst_stall_i | data_stall_i;
    live_exc    = (exc_type_m_i != EXC_NONE);
    redirect    = 1'b0;
    sel_type    = exc_type_m_i;
    sel_epc     = epc_m_i;
    exc_state_d = exc_state_q;
    exc_type_d  = exc_type_q;
    epc_d       = epc_q;
    case (exc_state_q)
      EXC_IDLE: begin
        if (live_exc && !mem_stall) begin
          redirect = 1'b1;
        end else if (live_exc) begin
          exc_state_d = EXC_HOLD;
          exc_type_d  = exc_type_m_i;
          epc_d       = epc_m_i;
        end else begin
          exc_state_d = EXC_IDLE;
        end
      end
      EXC_HOLD: begin
        sel_type = exc_type_q;
        sel_epc  = epc_q;
        if (!mem_stall) begin
          redirect    = 1'b1;
          exc_state_d = EXC_IDLE;
        end else begin
          exc_state_d = EXC_HOLD;
        end
      end
      default: begin
        exc_state_d = EXC_IDLE;
      end
    endcase
  end

  // ---------------- MDU occupancy ----------------
  // Load on start when idle, count down while the pipe moves, clear on redirect.
  always_comb begin
    mdu_idle  = (mdu_cnt_q == {MDU_W{1'b0}});
    mdu_cnt_d = mdu_cnt_q;
    if (redirect) begin
      mdu_cnt_d = {MDU_W{1'b0}};
    end else if (mdu_idle) begin
      mdu_cnt_d = mdu_start_e_i ? MDU_W'(MDU_LAT - 1) : {MDU_W{1'b0}};
    end else if (!mem_stall) begin
      mdu_cnt_d = mdu_cnt_q - MDU_W'(1);
    end else begin
      mdu_cnt_d = mdu_cnt_q;
    end
    mdu_stall  = (mdu_idle && mdu_start_e_i && MDU_MULT) || (mdu_cnt_q > MDU_W'(1));
    mdu_done_o = ((mdu_cnt_q == MDU_W'(1)) && !mem_stall) ||
                 (!MDU_MULT && mdu_start_e_i && !mem_stall);
  end

  // ---------------- stall / flush outputs ----------------
  // Redirect flushes everything and releases stalls; otherwise normal stalling.
  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_f_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_m_o = 1'b0;
    flush_w_o = 1'b0;
    new_pc_o  = 32'h0000_0000;
    if (redirect) begin
      flush_f_o = 1'b1;
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
      flush_m_o = 1'b1;
      flush_w_o = 1'b1;
      new_pc_o  = (sel_type == ERET_CODE) ? sel_epc : EXC_VEC;
    end else begin
      stall_m_o = mem_stall;
      stall_e_o = mem_stall | mdu_stall;
      stall_d_o = stall_e_o | hz;
      stall_f_o = stall_e_o | hz;
      flush_e_o = hz & ~stall_e_o;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mdu_cnt_q   <= {MDU_W{1'b0}};
      exc_state_q <= EXC_IDLE;
      exc_type_q  <= 32'h0000_0000;
      epc_q       <= 32'h0000_0000;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      exc_state_q <= exc_state_d;
      exc_type_q  <= exc_type_d;
      epc_q       <= epc_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_hz_q, perf_mem_q, perf_mdu_q;

  // Saturating event counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_hz_q  <= 32'h0000_0000;
      perf_mem_q <= 32'h0000_0000;
      perf_mdu_q <= 32'h0000_0000;
    end else begin
      perf_hz_q  <= sat_inc32(perf_hz_q, hz & ~(mem_stall | mdu_stall));
      perf_mem_q <= sat_inc32(perf_mem_q, mem_stall);
      perf_mdu_q <= sat_inc32(perf_mdu_q, mdu_stall & ~mem_stall);
    end
  end

  assign perf_hz_cyc_o  = perf_hz_q;
  assign perf_mem_cyc_o = perf_mem_q;
  assign perf_mdu_cyc_o = perf_mdu_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed-vector bench for hazard_ctrl_mc (default parameters).
module tb_hazard_ctrl_mc;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, wreg_e;
  logic        use_rs_d, use_rt_d, early_d, regwrite_e, memtoreg_e;
  logic [9:0]  wreg_s;
  logic [1:0]  regwrite_s, ready_s;
  logic        mdu_start_e, inst_stall, data_stall;
  logic [31:0] exc_type_m, epc_m;
  logic [1:0]  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_f, flush_d, flush_e, flush_m, flush_w;
  logic [31:0] new_pc;
  logic        mdu_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_hz_cyc, perf_mem_cyc, perf_mdu_cyc;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc dut (
    .clk(clk), .resetn(resetn),
    .rs_d_i(rs_d), .rt_d_i(rt_d), .use_rs_d_i(use_rs_d), .use_rt_d_i(use_rt_d),
    .early_d_i(early_d), .rs_e_i(rs_e), .rt_e_i(rt_e), .wreg_e_i(wreg_e),
    .regwrite_e_i(regwrite_e), .memtoreg_e_i(memtoreg_e),
    .wreg_s_i(wreg_s), .regwrite_s_i(regwrite_s), .ready_s_i(ready_s),
    .mdu_start_e_i(mdu_start_e), .inst_stall_i(inst_stall), .data_stall_i(data_stall),
    .exc_type_m_i(exc_type_m), .epc_m_i(epc_m),
    .fwd_a_d_o(fwd_a_d), .fwd_b_d_o(fwd_b_d), .fwd_a_e_o(fwd_a_e), .fwd_b_e_o(fwd_b_e),
    .stall_f_o(stall_f), .stall_d_o(stall_d), .stall_e_o(stall_e), .stall_m_o(stall_m),
    .flush_f_o(flush_f), .flush_d_o(flush_d), .flush_e_o(flush_e),
    .flush_m_o(flush_m), .flush_w_o(flush_w), .new_pc_o(new_pc),
`ifdef HAZARD_PERF_EN
    .perf_hz_cyc_o(perf_hz_cyc), .perf_mem_cyc_o(perf_mem_cyc), .perf_mdu_cyc_o(perf_mdu_cyc),
`endif
    .mdu_done_o(mdu_done)
  );

  // Count one comparison and report a mismatch.
  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    rs_d = 5'd0; rt_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0; wreg_e = 5'd0;
    use_rs_d = 1'b0; use_rt_d = 1'b0; early_d = 1'b0;
    regwrite_e = 1'b0; memtoreg_e = 1'b0;
    wreg_s = 10'd0; regwrite_s = 2'b00; ready_s = 2'b11;
    mdu_start_e = 1'b0; inst_stall = 1'b0; data_stall = 1'b0;
    exc_type_m = 32'd0; epc_m = 32'd0;
  endtask

  function automatic logic [31:0] stalls();
    return {28'd0, stall_f, stall_d, stall_e, stall_m};
  endfunction

  function automatic logic [31:0] flushes();
    return {27'd0, flush_f, flush_d, flush_e, flush_m, flush_w};
  endfunction

  initial begin
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    settle();
    chk_eq("rst_stall", stalls(), 32'h0);
    chk_eq("rst_flush", flushes(), 32'h0);
    chk_eq("rst_newpc", new_pc, 32'h0);
    chk_eq("rst_fwd", {24'd0, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}, 32'h0);
    chk_eq("rst_done", {31'd0, mdu_done}, 32'h0);

    // Forwarding priority.
    wreg_s = {5'd8, 5'd8}; regwrite_s = 2'b11; rs_e = 5'd8; settle();
    chk_eq("fwd_m_wins", {30'd0, fwd_a_e}, 32'd1);
    rs_e = 5'd0; wreg_s = {5'd0, 5'd0}; settle();
    chk_eq("fwd_reg0", {30'd0, fwd_a_e}, 32'd0);
    wreg_s = {5'd8, 5'd8}; regwrite_s = 2'b10; rt_e = 5'd8; settle();
    chk_eq("fwd_w_only", {30'd0, fwd_b_e}, 32'd2);
    wreg_s = {5'd8, 5'd3}; regwrite_s = 2'b11; settle();
    chk_eq("fwd_w_addr", {30'd0, fwd_b_e}, 32'd2);
    rt_e = 5'd0; rs_d = 5'd3; use_rs_d = 1'b1; settle();
    chk_eq("fwd_d_noearly", {30'd0, fwd_a_d}, 32'd0);
    chk_eq("noearly_stall", stalls(), 32'h0);
    early_d = 1'b1; settle();
    chk_eq("fwd_d_early", {30'd0, fwd_a_d}, 32'd1);
    chk_eq("early_rdy_stall", stalls(), 32'h0);
    ready_s = 2'b10; settle();
    chk_eq("early_nrdy_stall", stalls(), 32'hc);
    chk_eq("early_nrdy_flush", flushes(), 32'h4);
    idle_inputs();
    rs_d = 5'd7; use_rs_d = 1'b1; early_d = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd7; settle();
    chk_eq("early_from_e", stalls(), 32'hc);
    idle_inputs(); tick();

    // Load-use bubble, then clear when producer moves on.
    memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd9; rt_d = 5'd9; use_rt_d = 1'b1; settle();
    chk_eq("lu_stall", stalls(), 32'hc);
    chk_eq("lu_flush", flushes(), 32'h4);
    tick();
    memtoreg_e = 1'b0; regwrite_e = 1'b0; wreg_e = 5'd0; settle();
    chk_eq("lu_clear_stall", stalls(), 32'h0);
    chk_eq("lu_clear_flush", flushes(), 32'h0);
    idle_inputs(); tick();

    // MDU: 7 stall cycles, done in the 8th.
    mdu_start_e = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk_eq($sformatf("mdu_stall_c%0d", c), {31'd0, stall_e}, (c < 7) ? 32'd1 : 32'd0);
      chk_eq($sformatf("mdu_done_c%0d", c), {31'd0, mdu_done}, (c == 7) ? 32'd1 : 32'd0);
      tick();
    end
    mdu_start_e = 1'b0; settle();
    chk_eq("mdu_after", stalls(), 32'h0);
    chk_eq("mdu_after_done", {31'd0, mdu_done}, 32'd0);

    // MDU with a 2-cycle data stall mid-op: 10 cycles of occupancy.
    mdu_start_e = 1'b1;
    for (int c = 0; c < 10; c++) begin
      data_stall = (c == 3 || c == 4);
      settle();
      chk_eq($sformatf("mdux_stall_c%0d", c), {31'd0, stall_e}, (c < 9) ? 32'd1 : 32'd0);
      chk_eq($sformatf("mdux_done_c%0d", c), {31'd0, mdu_done}, (c == 9) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs(); settle();
    chk_eq("mdux_after", stalls(), 32'h0);

    // Immediate exceptions.
    exc_type_m = 32'd1; epc_m = 32'hbfc0_5555; settle();
    chk_eq("exc_flush", flushes(), 32'h1f);
    chk_eq("exc_stall", stalls(), 32'h0);
    chk_eq("exc_pc", new_pc, 32'hbfc0_0380);
    exc_type_m = 32'h0e; epc_m = 32'hbfc0_1234; settle();
    chk_eq("eret_pc", new_pc, 32'hbfc0_1234);
    exc_type_m = 32'd1; memtoreg_e = 1'b1; wreg_e = 5'd9; rt_d = 5'd9; use_rt_d = 1'b1; settle();
    chk_eq("exc_beats_hz_stall", stalls(), 32'h0);
    chk_eq("exc_beats_hz_flush", flushes(), 32'h1f);
    idle_inputs(); tick();

    // Deferred exception across a 3-cycle data stall, later withdrawn.
    data_stall = 1'b1; exc_type_m = 32'd4; epc_m = 32'hbfc0_7777; settle();
    chk_eq("hold_c0_flush", flushes(), 32'h0);
    chk_eq("hold_c0_stall", stalls(), 32'hf);
    tick();
    exc_type_m = 32'd0; settle();
    chk_eq("hold_c1_flush", flushes(), 32'h0);
    tick();
    exc_type_m = 32'h0e; epc_m = 32'hbfc0_aaaa; settle();
    chk_eq("hold_c2_flush", flushes(), 32'h0);
    chk_eq("hold_c2_stall", stalls(), 32'hf);
    tick();
    data_stall = 1'b0; settle();
    chk_eq("hold_redir_flush", flushes(), 32'h1f);
    chk_eq("hold_redir_stall", stalls(), 32'h0);
    chk_eq("hold_redir_pc", new_pc, 32'hbfc0_0380);
    tick();
    exc_type_m = 32'd0; settle();
    chk_eq("hold_back_idle", flushes(), 32'h0);
    chk_eq("hold_back_pc", new_pc, 32'h0);
    idle_inputs(); tick();

    // Reset while in HOLD with the MDU counter at 5.
    mdu_start_e = 1'b1;
    tick(); tick(); tick();
    data_stall = 1'b1; exc_type_m = 32'd4; settle();
    chk_eq("pre_rst_flush", flushes(), 32'h0);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; idle_inputs(); settle();
    chk_eq("post_rst_stall", stalls(), 32'h0);
    chk_eq("post_rst_flush", flushes(), 32'h0);
    chk_eq("post_rst_done", {31'd0, mdu_done}, 32'd0);
    tick(); settle();
    chk_eq("post_rst_stall2", stalls(), 32'h0);
    exc_type_m = 32'd1; settle();
    chk_eq("post_rst_exc", flushes(), 32'h1f);
    chk_eq("post_rst_pc", new_pc, 32'hbfc0_0380);
    idle_inputs(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage MIPS core, succeeding the combinational hazard block.
- Generalises forwarding to FWD_STAGES producer stages after E, with per-stage result-ready flags.
- Owns a multi-cycle MDU occupancy counter; MDU busy is no longer an external input.
- Owns an exception-redirect FSM that defers a flush that arrives during a memory stall instead of dropping it.
- Sits beside the datapath and drives all stall, flush and forward-select signals plus the redirect PC.

Parameters:
FWD_STAGES, 2, number of producer stages after E (index 0 = M, 1 = W, ...)
MDU_LAT, 8, total E-stage cycles a mul/div occupies (>=1)
EXC_VEC, 32'hbfc00380, general exception entry PC
ERET_CODE, 32'h0000_000e, excepttype value meaning ERET (redirect to EPC)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
rs_d, rt_d  in  5  D-stage source registers
use_rs_d, use_rt_d  in  1  D instruction reads rs/rt
early_d  in  1  D instruction consumes operands in D (branch, jr/jalr)
rs_e, rt_e  in  5  E-stage sources
wreg_e  in  5  E destination; regwrite_e, memtoreg_e  in  1 each
wreg_s  in  5*FWD_STAGES  destinations of stages after E, stage k at bits [5k+4:5k]
regwrite_s, ready_s  in  FWD_STAGES each  stage writes a register / result is available this cycle
mdu_start_e  in  1  multi-cycle op present in E
inst_stall, data_stall  in  1 each  bus stalls
exc_type_m, epc_m  in  32 each  M-stage excepttype (0 = none) and EPC
fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e  out  SEL_W  0 = regfile, k = stage k-1
stall_f, stall_d, stall_e, stall_m  out  1
flush_f, flush_d, flush_e, flush_m, flush_w  out  1
new_pc  out  32  redirect target, valid when flush_f = 1
mdu_done  out  1  MDU result valid this cycle

Behaviour:
- Reset: mdu_cnt = 0, exc FSM = IDLE, latched type/EPC = 0.
- All outputs are combinational from inputs and state. After reset and with inputs idle, every stall, flush and fwd output is 0, and new_pc = 0.
- mem_stall = inst_stall | data_stall.
- Forward select:
  - Reg 0 is never forwarded.
  - Youngest matching stage wins, i.e. lowest k with regwrite_s[k] and wreg_s[k] == src.
  - D selects apply only when early_d is set; otherwise they are 0.
- Hazard stall (hz):
  - Load-use: memtoreg_e, and wreg_e matches a used D source.
  - Early operand from E: early_d, regwrite_e, and wreg_e matches a used D source.
  - Early operand not ready: early_d, and the youngest matching stage k has ready_s[k] = 0.
- MDU counter:
  - Idle when mdu_cnt = 0.
  - When idle and mdu_start_e = 1: load MDU_LAT-1.
  - While non-zero: decrement each cycle mem_stall = 0; hold while mem_stall = 1.
  - mdu_stall = (idle & mdu_start_e & MDU_LAT>1) | (mdu_cnt > 1).
  - mdu_done = (mdu_cnt == 1 & !mem_stall) | (MDU_LAT == 1 & mdu_start_e & !mem_stall).
  - mdu_start_e while busy is ignored.
  - The E instruction occupies exactly MDU_LAT cycles absent mem_stall.
- Exception FSM:
  - IDLE, exc_type_m != 0, !mem_stall: redirect this cycle.
  - IDLE, exc_type_m != 0, mem_stall: latch type and EPC, go to HOLD, no flush yet.
  - HOLD: ignore new exc_type_m. When mem_stall drops, redirect using the latched values, then return to IDLE.
  - Redirect cycle: assert all flush_* and set stall_* = 0.
  - new_pc = latched or live EPC when type == ERET_CODE, else EXC_VEC.
  - Redirect also clears mdu_cnt.
- Stalls when not redirecting:
  - stall_m = mem_stall.
  - stall_e = mem_stall | mdu_stall.
  - stall_d = stall_f = stall_e | hz.
  - flush_e = hz & !stall_e (bubble).
  - flush_f/d/m/w = 0.
- Simultaneous events:
  - Redirect beats every stall.
  - In HOLD the pipeline stays stalled by mem_stall.
  - Reset mid-MDU or mid-HOLD returns all state to reset values.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds outputs perf_hz_cyc, perf_mem_cyc, perf_mdu_cyc (32 bits each).
- These count cycles with hz & !stall_e, mem_stall, and mdu_stall & !mem_stall respectively.
- Counters saturate at all-ones, reset to 0, and are not cleared by flush.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - SEL_W = $clog2(FWD_STAGES+1)
  - exc FSM state enum {EXC_IDLE, EXC_HOLD}
  - EXC_VEC and ERET_CODE defaults
  - the excepttype code constants
- One sub-module: hazard_fwd_sel. It is the priority encoder for one source against the stage vector, instantiated four times.

Test Plan:
- wreg_s = {5'd8, 5'd8}, regwrite_s = 2'b11, rs_e = 8 -> fwd_a_e = 1 (stage M wins). With rs_e = 0 -> fwd_a_e = 0.
- memtoreg_e = 1, wreg_e = 9, rt_d = 9, use_rt_d = 1 -> stall_f = stall_d = 1 and flush_e = 1 for one cycle. Next cycle (producer moves on): all clear.
- MDU_LAT = 8, mdu_start_e pulse -> stall_e high for 7 cycles and mdu_done in the 8th. A 2-cycle data_stall mid-op extends occupancy to 10 cycles.
- exc_type_m = 1 with no stall -> all flushes same cycle, new_pc = 32'hbfc00380. exc_type_m = 32'h0e, epc_m = 32'hbfc01234 -> new_pc = 32'hbfc01234.
- exc_type_m = 4 arrives during a 3-cycle data_stall and is then withdrawn -> no flush during the stall. When stall drops: flush with new_pc = 32'hbfc00380, then FSM returns to IDLE.
- resetn = 0 while in HOLD with mdu_cnt = 5 -> next cycle: no stalls, no flushes, mdu_done = 0, and a later exception is taken normally.
